// File: rtl/dcache_store_tap_if.sv
// Processor/D-cache snoop bus plus the checker-side tap stream and statistics.
interface dcache_store_tap_if #(
  parameter int unsigned CNT_W = 16
);
  logic [29:0]      proc_addr;
  logic [31:0]      proc_wdata;
  logic             proc_read;
  logic             proc_write;
  logic             proc_stall;
  logic [1:0]       hit_or_miss;
  logic             tap_ready;
  logic             tap_valid;
  logic [31:0]      tap_data;
  logic             armed;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  // Environment side: drives the processor bus and the checker ready.
  modport master (
    output proc_addr, proc_wdata, proc_read, proc_write, proc_stall, hit_or_miss, tap_ready,
    input  tap_valid, tap_data, armed, done, overflow, acc_cnt, hit_cnt, miss_cnt
  );

  // Tap side: observes the bus and produces the stream and statistics.
  modport slave (
    input  proc_addr, proc_wdata, proc_read, proc_write, proc_stall, hit_or_miss, tap_ready,
    output tap_valid, tap_data, armed, done, overflow, acc_cnt, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_store_tap.sv
// Store tap: turns accepted stores to the test port into a FIFO stream for
// the result checker, gated by begin/end marker stores, with window statistics.
module dcache_store_tap #(
  parameter logic [29:0] TAP_ADDR  = 30'hFF,
  parameter logic [31:0] BEGIN_SYM = 32'h0000_0932,
  parameter logic [31:0] END_SYM   = 32'h0000_0D5D,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_W     = 16
) (
  input logic               clk,
  input logic               rst,
  dcache_store_tap_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]      PtrOne = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [31:0]      r_mem [DEPTH];
  logic             r_overflow;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic w_accept;
  logic w_tap_st;
  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_full;
  logic w_wr_en;

  // A stalled request only counts on its single non-stalled cycle, so no edge detection.
  assign w_accept = (bus.proc_read ^ bus.proc_write) & ~bus.proc_stall;
  assign w_tap_st = w_accept & bus.proc_write & (bus.proc_addr == TAP_ADDR);
  assign w_push   = w_tap_st & (r_state == StArmed);

  // Extra pointer bit separates full from empty when the index bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & bus.tap_ready;
  // When full, a simultaneous pop frees the head slot that the push then reuses.
  assign w_wr_en = w_push & (~w_full | w_pop);

  // Next-state logic for the capture window.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_tap_st && (bus.proc_wdata == BEGIN_SYM)) w_state_next = StArmed;
      StArmed: if (w_tap_st && (bus.proc_wdata == END_SYM))   w_state_next = StDone;
      StDone:  w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  // FIFO storage; contents are masked by the empty flag, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr[AW-1:0]] <= bus.proc_wdata;
  end

  // FIFO pointers and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + PtrOne;
      if (w_pop)   r_rptr <= r_rptr + PtrOne;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Saturating statistics, counted only inside the armed window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_cnt  <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == StArmed) begin
      if (w_accept && (r_acc_cnt != '1)) r_acc_cnt <= r_acc_cnt + CntOne;
      if ((bus.hit_or_miss == 2'b01) && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CntOne;
      if ((bus.hit_or_miss == 2'b10) && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CntOne;
    end
  end

  assign bus.tap_valid = ~w_empty;
  assign bus.tap_data  = w_empty ? 32'h0 : r_mem[r_rptr[AW-1:0]];
  assign bus.armed     = (r_state == StArmed);
  assign bus.done      = (r_state == StDone);
  assign bus.overflow  = r_overflow;
  assign bus.acc_cnt   = r_acc_cnt;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.miss_cnt  = r_miss_cnt;

endmodule
